collector: RTL and testbench

//  Receive side of the dispatcher lane stream: accepts four W-bit lanes (d1..d4)
//  per beat and reassembles four beats into a 4x4 result matrix.

---
 rtl/collector.sv | 148 ++++++++++++++
 tb/tb_collector.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/collector.sv
// -----------------------------------------------------------------------------
// collector
//   Receive side of the dispatcher lane stream. Accepts four W-bit lanes per
//   beat and reassembles four beats into a 4x4 matrix, filled in row order
//   or in transposed (column) order. One full matrix is delivered per
//   start/done transaction. The consumer releases it with ack.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      begin a new collection; samples transpose
//   transpose  0: beat b fills row b+1, 1: beat b fills column b+1
//   valid      d1..d4 carry a beat this cycle
//   d1..d4     lane data; dk is element k of the current beat
//   ack        consumer has taken m; releases done
//   ready      a beat is accepted this cycle (COLLECT state)
//   done       matrix complete; held until ack
//   beat       index of the next beat to be written (0..3)
//   overrun    sticky: valid seen while ready=0
//   m          matrix; m[W*(4*i+j) +: W] = element (row i+1, col j+1)
// -----------------------------------------------------------------------------
module collector #(
  parameter int W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            transpose,
  input  logic            valid,
  input  logic [W-1:0]    d1,
  input  logic [W-1:0]    d2,
  input  logic [W-1:0]    d3,
  input  logic [W-1:0]    d4,
  input  logic            ack,
  output logic            ready,
  output logic            done,
  output logic [1:0]      beat,
  output logic            overrun,
  output logic [16*W-1:0] m
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t         state_q;
  logic           ready_q;
  logic           done_q;
  logic [1:0]     beat_q;
  logic           overrun_q;
  logic           tr_q;
  logic [W-1:0]   m_q [16];
  logic [W-1:0]   lane [4];

  // Flat element index (4*row + col) for lane k of beat b.
  function automatic logic [3:0] elem_idx(input logic tr, input logic [1:0] b,
                                          input logic [1:0] k);
    return tr ? {k, b} : {b, k};
  endfunction

  always_comb begin
    lane[0] = d1;
    lane[1] = d2;
    lane[2] = d3;
    lane[3] = d4;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      beat_q    <= 2'd0;
      overrun_q <= 1'b0;
      tr_q      <= 1'b0;
      // NOTE: the matrix store is reset on purpose: the consumer must observe
      // m=0 immediately after reset, so it cannot be a plain RAM.
      for (int i = 0; i < 16; i++) m_q[i] <= '0;
    end else begin
      // ready_q mirrors the COLLECT state, so this flags exactly IDLE/DONE.
      if (valid && !ready_q) overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_COLLECT;
            ready_q <= 1'b1;
            beat_q  <= 2'd0;
            tr_q    <= transpose;
          end
        end

        S_COLLECT: begin
          // start has priority: a beat presented on the same cycle is dropped.
          if (start) begin
            beat_q <= 2'd0;
            tr_q   <= transpose;
          end else if (valid) begin
            for (int k = 0; k < 4; k++)
              m_q[elem_idx(tr_q, beat_q, 2'(k))] <= lane[k];
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              state_q <= S_DONE;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          if (ack) begin
            done_q <= 1'b0;
            if (start) begin
              state_q <= S_COLLECT;
              ready_q <= 1'b1;
              beat_q  <= 2'd0;
              tr_q    <= transpose;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: combinational blocks assign every output bit on every pass, so no
  // latches are inferred.
  always_comb begin
    for (int i = 0; i < 16; i++) m[W*i +: W] = m_q[i];
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign beat    = beat_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_collector.sv
// -----------------------------------------------------------------------------
// tb_collector
//   Directed bench for collector. Each transaction pushes its expected matrix
//   into a scoreboard queue; a monitor pops and compares on every rising edge
//   of done. Control outputs (ready, done, beat, overrun) are checked inline.
// -----------------------------------------------------------------------------
module tb_collector;

  localparam int W  = 32;
  localparam int MW = 16 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, transpose, valid, ack;
  logic [W-1:0]  d1, d2, d3, d4;
  logic          ready, done, overrun;
  logic [1:0]    beat;
  logic [MW-1:0] m;

  int n_vec  = 0;
  int n_fail = 0;

  logic [MW-1:0] exp_q [$];

  collector #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .transpose (transpose),
    .valid     (valid),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .d4        (d4),
    .ack       (ack),
    .ready     (ready),
    .done      (done),
    .beat      (beat),
    .overrun   (overrun),
    .m         (m)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [MW-1:0] act,
                       input logic [MW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic tr);
    start = 1'b1; transpose = tr;
    step();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [W-1:0] a, b, c, d);
    valid = 1'b1; d1 = a; d2 = b; d3 = c; d4 = d;
    step();
    valid = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  // Scoreboard monitor: one expected matrix per rising edge of done.
  initial begin : monitor
    logic done_prev;
    logic [MW-1:0] e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_prev = 1'b0;
      end else begin
        if (done && !done_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("matrix", m, e);
          end
        end
        done_prev = done;
      end
    end
  end

  logic [W-1:0] fp [16] = '{
    32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
    32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
    32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
    32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000
  };
  int gaps [4] = '{1, 3, 2, 1};

  initial begin : stim
    logic [MW-1:0] e;
    logic [MW-1:0] fp_mat;
    rst = 1'b1; start = 1'b0; transpose = 1'b0; valid = 1'b0; ack = 1'b0;
    d1 = '0; d2 = '0; d3 = '0; d4 = '0;
    repeat (2) step();

    // Reset state
    check("rst ready",   ready,   0);
    check("rst done",    done,    0);
    check("rst beat",    beat,    0);
    check("rst overrun", overrun, 0);
    check("rst m",       m,       0);
    rst = 1'b0;
    step();

    // 1: row mode, element e = e
    for (int i = 0; i < 16; i++) e[W*i +: W] = W'(i);
    exp_q.push_back(e);
    do_start(1'b0);
    check("t1 ready", ready, 1);
    check("t1 beat0", beat, 0);
    for (int b = 0; b < 4; b++) begin
      send_beat(W'(4*b), W'(4*b+1), W'(4*b+2), W'(4*b+3));
      if (b == 1) check("t1 beat2", beat, 2);
    end
    check("t1 done", done, 1);
    check("t1 ready low", ready, 0);
    check("t1 beat wrap", beat, 0);
    do_ack();
    check("t1 done cleared", done, 0);

    // 2: transposed, element (i,j) = 4j+i
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) e[W*(4*i+j) +: W] = W'(4*j+i);
    exp_q.push_back(e);
    do_start(1'b1);
    for (int b = 0; b < 4; b++)
      send_beat(W'(4*b), W'(4*b+1), W'(4*b+2), W'(4*b+3));
    check("t2 done", done, 1);
    do_ack();

    // 3: FP32 values with idle gaps between beats
    for (int i = 0; i < 16; i++) fp_mat[W*i +: W] = fp[i];
    exp_q.push_back(fp_mat);
    do_start(1'b0);
    for (int b = 0; b < 4; b++) begin
      repeat (gaps[b]) step();
      if (b == 3) check("t3 no early done", done, 0);
      send_beat(fp[4*b], fp[4*b+1], fp[4*b+2], fp[4*b+3]);
    end
    check("t3 done", done, 1);
    do_ack();

    // 5: restart after 2 beats, start+valid collision, then 4 beats of A5
    for (int i = 0; i < 16; i++) e[W*i +: W] = 32'hA5A5A5A5;
    exp_q.push_back(e);
    do_start(1'b1);
    send_beat(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    send_beat(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
    check("t5 beat2", beat, 2);
    start = 1'b1; transpose = 1'b0; valid = 1'b1;
    d1 = 32'h99999999; d2 = 32'h99999999; d3 = 32'h99999999; d4 = 32'h99999999;
    step();
    start = 1'b0; valid = 1'b0;
    check("t5 collide beat", beat, 0);
    check("t5 collide overrun", overrun, 0);
    check("t5 collide ready", ready, 1);
    for (int b = 0; b < 4; b++)
      send_beat(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
    check("t5 done", done, 1);
    step();
    do_ack();
    step();

    // 4: valid in IDLE is dropped and sets overrun; ack in COLLECT ignored
    for (int i = 0; i < 16; i++) e[W*i +: W] = 32'hA5A5A5A5;
    send_beat(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    check("t4 overrun", overrun, 1);
    check("t4 m unchanged", m, e);
    do_start(1'b0);
    do_ack();
    check("t4 ack ready", ready, 1);
    check("t4 ack done", done, 0);
    check("t4 ack beat", beat, 0);
    check("t4 overrun sticky", overrun, 1);
    for (int i = 0; i < 16; i++) e[W*i +: W] = 32'h10000000 + W'(i);
    exp_q.push_back(e);
    for (int b = 0; b < 4; b++)
      send_beat(32'h10000000 + W'(4*b), 32'h10000000 + W'(4*b+1),
                32'h10000000 + W'(4*b+2), 32'h10000000 + W'(4*b+3));
    check("t4 done", done, 1);

    // 6: start alone in DONE ignored; start+ack restarts; reset mid-beat
    do_start(1'b1);
    check("t6 start ignored done", done, 1);
    check("t6 start ignored ready", ready, 0);
    check("t6 m stable", m, e);
    start = 1'b1; ack = 1'b1; transpose = 1'b0;
    step();
    start = 1'b0; ack = 1'b0;
    check("t6 restart ready", ready, 1);
    check("t6 restart done", done, 0);
    send_beat(32'h1, 32'h2, 32'h3, 32'h4);
    send_beat(32'h5, 32'h6, 32'h7, 32'h8);
    valid = 1'b1; d1 = 32'h9; d2 = 32'hA; d3 = 32'hB; d4 = 32'hC;
    #2 rst = 1'b1;
    #1;
    check("t6 rst m", m, 0);
    check("t6 rst done", done, 0);
    check("t6 rst ready", ready, 0);
    check("t6 rst beat", beat, 0);
    check("t6 rst overrun", overrun, 0);
    valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
